// File: rtl/ysyx_23060203_mdu.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide on an
// unsigned core with sign fix-up; valid/ready on both request and result sides.
module ysyx_23060203_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [2:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [5:0]        r_cnt;
    logic [2:0]        r_funct;
    logic [TAG_W-1:0]  r_tag;
    logic [2*XLEN-1:0] r_opa;   // multiplicand (shifted left) or dividend (MSB consumed first)
    logic [XLEN-1:0]   r_opb;   // multiplier (shifted right) or divisor
    logic [2*XLEN-1:0] r_acc;   // product, or quotient in the low half
    logic [XLEN-1:0]   r_rem;
    logic              r_neg;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_data;
    logic [TAG_W-1:0]  r_out_tag;

    logic              w_sa_en, w_sb_en, w_sa, w_sb, w_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_div_shift, w_div_trial;
    logic [2*XLEN-1:0] w_mul_sum, w_prod;
    logic [XLEN-1:0]   w_quo, w_remv, w_fix_res;

    always_comb begin
        // MULHU, DIVU and REMU treat both operands as unsigned; MULHSU only rs2
        w_sa_en  = (in_funct != 3'b011) && (in_funct != 3'b101) && (in_funct != 3'b111);
        w_sb_en  = w_sa_en && (in_funct != 3'b010);
        w_sa     = in_a[XLEN-1] & w_sa_en;
        w_sb     = in_b[XLEN-1] & w_sb_en;
        w_abs_a  = w_sa ? (~in_a + 1'b1) : in_a;
        w_abs_b  = w_sb ? (~in_b + 1'b1) : in_b;
        w_neg    = (in_funct[2] && in_funct[1]) ? w_sa : (w_sa ^ w_sb);

        w_b_zero  = (in_b == '0);
        w_ovf     = in_funct[2] && !in_funct[0] && (in_a == INT_MIN) && (&in_b);
        w_special = in_funct[2] && (w_b_zero || w_ovf);
        if (w_b_zero) begin
            w_special_res = in_funct[1] ? in_a : '1;
        end else begin
            w_special_res = in_funct[1] ? '0 : INT_MIN;
        end

        w_div_shift = {r_rem, r_opa[XLEN-1]};
        w_div_trial = w_div_shift - {1'b0, r_opb};
        w_mul_sum   = r_acc + (r_opb[0] ? r_opa : '0);

        w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
        w_quo  = r_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_remv = r_neg ? (~r_rem + 1'b1) : r_rem;
        case (r_funct)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_remv;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_funct     <= '0;
            r_tag       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_funct <= in_funct;
                        r_tag   <= in_tag;
                        r_opa   <= {{XLEN{1'b0}}, w_abs_a};
                        r_opb   <= w_abs_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_out_data  <= w_special_res;
                            r_out_tag   <= in_tag;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    r_opa <= r_opa << 1;
                    if (r_funct[2]) begin
                        r_rem <= w_div_trial[XLEN] ? w_div_shift[XLEN-1:0]
                                                   : w_div_trial[XLEN-1:0];
                        r_acc <= {r_acc[2*XLEN-2:0], ~w_div_trial[XLEN]};
                    end else begin
                        r_acc <= w_mul_sum;
                        r_opb <= r_opb >> 1;
                    end
                    if (r_cnt == LAST_ITER) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_out_data  <= w_fix_res;
                    r_out_tag   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_ysyx_23060203_mdu.sv
// Testbench for ysyx_23060203_mdu: directed and randomized RV32M ops, expected results queued
// by the driver and checked by an independent monitor on result handshakes.
module tb_ysyx_23060203_mdu;

    logic        clock = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_data;
    logic [2:0]  in_funct;
    logic [4:0]  in_tag, out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_d[$];
    logic [4:0]  exp_t[$];

    ysyx_23060203_mdu #(.XLEN(32), .TAG_W(5)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_funct  (in_funct),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics with 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: r = sa * sb;
            3'd1: begin r = sa * sb; r = r >>> 32; end
            3'd2: begin r = sa * ub; r = r >>> 32; end
            3'd3: begin r = ua * ub; r = r >> 32; end
            3'd4: r = (b == 0) ? -1 : sa / sb;
            3'd5: r = (b == 0) ? -1 : ua / ub;
            3'd6: r = (b == 0) ? sa : sa % sb;
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 0;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Handshake only; inputs are scrambled right after acceptance
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] t);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
        if (!in_ready) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        in_funct = f; in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_funct = 3'($urandom); in_tag = 5'($urandom);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input logic [31:0] expd);
        int n = 0;
        exp_d.push_back(expd);
        exp_t.push_back(t);
        start_op(f, a, b, t);
        // edges after the acceptance edge until out_valid is seen
        while (!out_valid && n < 60) begin @(posedge clock); #1; n++; end
        chk("latency", 32'(n), 32'(exp_latency(f, a, b)));
    endtask

    task automatic wait_retire();
        int n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 100) begin @(posedge clock); #1; n++; end
        chk("retire", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n && out_valid) begin
                if (exp_d.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    chk("out_data", out_data, exp_d.pop_front());
                    chk("out_tag", {27'b0, out_tag}, {27'b0, exp_t.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0]  f;
        logic [31:0] a, b;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_funct = '0; in_tag = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset_n = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);        wait_retire();
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000); wait_retire();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF); wait_retire();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE); wait_retire();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);         wait_retire();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);         wait_retire();
        issue(3'd5, 32'd100, 32'd7, 5'd6, 32'd14);                      wait_retire();
        issue(3'd7, 32'd100, 32'd7, 5'd7, 32'd2);                       wait_retire();
        issue(3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);                 wait_retire();
        issue(3'd6, 32'd5, 32'd0, 5'd10, 32'd5);                        wait_retire();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000); wait_retire();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);        wait_retire();

        // backpressure: result and tag must hold while out_ready is low
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 5'd21, 32'd14);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_data", out_data, 32'd14);
            chk("bp_out_tag", {27'b0, out_tag}, 32'd21);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_retire_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_retire_in_ready", {31'b0, in_ready}, 32'd1);

        // flush after the tenth iteration, then reset mid-calculation
        start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13);
        repeat (10) @(posedge clock);
        #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        start_op(3'd4, 32'd1000, 32'd3, 5'd14);
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_out_data", out_data, 32'd0);
        repeat (40) @(posedge clock);
        #1;
        chk("dropped_no_output", {31'b0, out_valid}, 32'd0);
        issue(3'd0, 32'd3, 32'd4, 5'd15, 32'd12); wait_retire();

        // randomized ops with random result backpressure
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = pick();
            b = pick();
            out_ready = 1'($urandom);
            issue(f, a, b, 5'($urandom), ref_model(f, a, b));
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            wait_retire();
        end

        repeat (3) @(posedge clock);
        chk("queue_drained", 32'(exp_d.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
